led_seq_ctrl: RTL and testbench
===============================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter N_LED, default 8, number of LED outputs (legal 2..16).
REQ-002 SHALL have parameter TICK_DIV, default 50_000_000, clk cycles per base tick (1 s at 50 MHz; legal >= 2).
REQ-003 SHALL have parameter DIV_W, default 27, prescaler counter width; must satisfy 2^DIV_W >= TICK_DIV.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cfg_valid  in  1  configuration offer.
REQ-007 cfg_ready  out  1  configuration accepted when cfg_valid and cfg_ready are both high on a clk edge.
REQ-008 cfg_mode  in  2  pattern: 00 OFF, 01 BLINK, 10 CHASE, 11 BOUNCE.
REQ-009 cfg_rate  in  4  one pattern step every cfg_rate+1 base ticks.
REQ-010 start  in  1  level, sampled each edge; begin or resume sequencing.
REQ-011 pause  in  1  level; freeze sequencing.
REQ-012 stop  in  1  level; abort to idle.
REQ-013 led  out  N_LED  registered LED drive.
REQ-014 busy  out  1  high in RUN or HOLD.
REQ-015 step_pulse  out  1  one-cycle strobe on each pattern step.

Function
REQ-016 FSM states IDLE, RUN, HOLD; priority per edge: stop > pause > start.
REQ-017 IDLE: start -> RUN, led loaded with initial pattern next edge (OFF 0, BLINK all ones, CHASE 1, BOUNCE 1 with direction up).
REQ-018 RUN: stop -> IDLE; pause -> HOLD; else stay.
REQ-019 HOLD: stop -> IDLE; start with pause low -> RUN, pattern, direction, prescaler and rate count all retained.
REQ-020 Entry to IDLE clears led, prescaler, rate counter on the same edge.
REQ-021 cfg_ready high exactly in cycles where state is IDLE; a handshake in IDLE latches cfg_mode and cfg_rate; cfg_valid ignored in RUN/HOLD.
REQ-022 Handshake and start on the same edge: new configuration takes effect for that start.
REQ-023 Prescaler counts 0..TICK_DIV-1 only in RUN; base tick when count == TICK_DIV-1, then wraps to 0; holds in HOLD.
REQ-024 Rate counter counts base ticks 0..rate; at rate on a tick it wraps to 0 and a step occurs on that same edge.
REQ-025 First step occurs (rate+1)*TICK_DIV clk cycles after the RUN-entry edge.
REQ-026 Step: BLINK inverts all bits; CHASE rotates left, MSB wraps to bit 0; OFF keeps 0 (step_pulse still fires).
REQ-027 BOUNCE step: shift toward direction; at bit N_LED-1 moving up, next is bit N_LED-2, direction down; at bit 0 moving down, next is bit 1, direction up; exactly one bit set always.
REQ-028 step_pulse high for the one cycle after each step edge, coincident with the updated led value.
REQ-029 stop on a step edge: IDLE wins, led 0, no step_pulse.

Reset
REQ-030 While reset is high: state IDLE, led 0, busy 0, step_pulse 0, cfg_ready 0, mode OFF, rate 0, direction up, counters 0.
REQ-031 cfg_ready rises on the first clk edge after reset deasserts; reset mid-RUN takes effect immediately, without waiting for clk.

Structure
REQ-032 Package led_seq_pkg SHALL hold the mode encodings and the FSM state type.
REQ-033 Prescaler SHALL be sub-module tick_prescaler (parameters TICK_DIV, DIV_W; inputs enable, clear; output tick).

Verification (TICK_DIV=4, N_LED=8)
REQ-034 cfg CHASE rate 0, start -> led 0x01; then 0x02 4 cycles later, with step_pulse; after 0x80 -> 0x01.
REQ-035 cfg BOUNCE rate 1 -> steps every 8 cycles: 0x01,0x02,...,0x80,0x40,...,0x01,0x02.
REQ-036 BLINK rate 0, pause 2 cycles after a step for 10 cycles, then start -> next toggle 2 cycles after resume, led unchanged during HOLD.
REQ-037 stop and start same edge from RUN -> IDLE, led 0x00, busy 0, cfg_ready 1.
REQ-038 cfg_valid in RUN with mode OFF -> ignored, pattern continues; reset mid-RUN -> led 0x00 asynchronously, mode OFF after release.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: pattern mode encodings and FSM states.
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'b00,
      MODE_BLINK  = 2'b01,
      MODE_CHASE  = 2'b10,
      MODE_BOUNCE = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10
   } state_e;

endpackage

// File: rtl/led_seq_tick_prescaler.sv
// Base-tick prescaler: counts clk cycles while enabled and strobes tick on the last count of each period.
module tick_prescaler #(
   parameter int TICK_DIV = 50_000_000,
   parameter int DIV_W    = 27
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] count;

   assign tick = enable && (count == LAST);

   // Count 0..TICK_DIV-1 while enabled, wrap after the last count, freeze otherwise; clear wins over counting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         if (count == LAST) begin
            count <= '0;
         end else begin
            count <= count + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: configurable OFF/BLINK/CHASE/BOUNCE patterns stepped at a programmable tick rate.
module led_seq_ctrl
   import led_seq_pkg::*;
#(
   parameter int N_LED    = 8,
   parameter int TICK_DIV = 50_000_000,
   parameter int DIV_W    = 27
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [1:0]       cfg_mode,
   input  logic [3:0]       cfg_rate,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   output logic [N_LED-1:0] led,
   output logic             busy,
   output logic             step_pulse
);

   state_e           state;
   state_e           next_state;
   mode_e            mode_q;
   mode_e            eff_mode;
   logic [3:0]       rate_q;
   logic [3:0]       rate_cnt;
   logic             dir_up;
   logic             dir_next;
   logic [N_LED-1:0] led_next;
   logic             handshake;
   logic             go_idle;
   logic             run_entry;
   logic             tick;
   logic             step;

   assign handshake = cfg_valid && cfg_ready;
   assign eff_mode  = handshake ? mode_e'(cfg_mode) : mode_q;
   assign go_idle   = (next_state == ST_IDLE);
   assign run_entry = (state == ST_IDLE) && (next_state == ST_RUN);
   assign step      = tick && (rate_cnt == rate_q) && !go_idle;
   assign busy      = (state != ST_IDLE);

   tick_prescaler #(
      .TICK_DIV (TICK_DIV),
      .DIV_W    (DIV_W)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .enable (state == ST_RUN),
      .clear  (go_idle),
      .tick   (tick)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode with stop taking precedence over pause, and pause over start.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (!stop && !pause && start) next_state = ST_RUN;
         ST_RUN: begin
            if (stop) next_state = ST_IDLE;
            else if (pause) next_state = ST_HOLD;
         end
         ST_HOLD: begin
            if (stop) next_state = ST_IDLE;
            else if (start && !pause) next_state = ST_RUN;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Next LED pattern: cleared on return to idle, seeded on a fresh start, advanced on each step.
   always_comb begin
      led_next = led;
      dir_next = dir_up;
      if (go_idle) begin
         led_next = '0;
         dir_next = 1'b1;
      end else if (run_entry) begin
         dir_next = 1'b1;
         case (eff_mode)
            MODE_OFF:   led_next = '0;
            MODE_BLINK: led_next = '1;
            default:    led_next = N_LED'(1);
         endcase
      end else if (step) begin
         case (mode_q)
            MODE_BLINK: led_next = ~led;
            MODE_CHASE: led_next = {led[N_LED-2:0], led[N_LED-1]};
            MODE_BOUNCE: begin
               if (dir_up) begin
                  if (led[N_LED-1]) begin
                     led_next = led >> 1;
                     dir_next = 1'b0;
                  end else begin
                     led_next = led << 1;
                  end
               end else begin
                  if (led[0]) begin
                     led_next = led << 1;
                     dir_next = 1'b1;
                  end else begin
                     led_next = led >> 1;
                  end
               end
            end
            default: led_next = '0;
         endcase
      end
   end

   // Latch a new configuration whenever it is accepted in idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q <= MODE_OFF;
         rate_q <= '0;
      end else if (handshake) begin
         mode_q <= mode_e'(cfg_mode);
         rate_q <= cfg_rate;
      end
   end

   // Ready tracks idle one edge behind reset release, so it stays low until the first clock after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_ready <= 1'b0;
      end else begin
         cfg_ready <= go_idle;
      end
   end

   // LED and bounce direction registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led    <= '0;
         dir_up <= 1'b1;
      end else begin
         led    <= led_next;
         dir_up <= dir_next;
      end
   end

   // Count base ticks up to the configured rate; the wrap edge is the step edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rate_cnt <= '0;
      end else if (go_idle) begin
         rate_cnt <= '0;
      end else if (tick) begin
         if (rate_cnt == rate_q) begin
            rate_cnt <= '0;
         end else begin
            rate_cnt <= rate_cnt + 4'd1;
         end
      end
   end

   // Step strobe lines up with the updated LED value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_pulse <= 1'b0;
      end else begin
         step_pulse <= step;
      end
   end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Testbench for led_seq_ctrl: directed vector table for the documented scenarios plus randomized traffic against a behavioural model.
module tb_led_seq_ctrl;

   localparam int N_LED    = 8;
   localparam int TICK_DIV = 4;
   localparam int DIV_W    = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [1:0]       cfg_mode;
   logic [3:0]       cfg_rate;
   logic             start;
   logic             pause;
   logic             stop;
   logic [N_LED-1:0] led;
   logic             busy;
   logic             step_pulse;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       valid;
      logic [1:0] mode;
      logic [3:0] rate;
      logic       start;
      logic       pause;
      logic       stop;
      int         n;
      logic [7:0] led;
      logic       busy;
      logic       ready;
      logic       pulse;
   } vec_t;

   vec_t vecs[29];

   // Behavioural model: state as an int, pattern as a position/phase, timing as one elapsed-cycle count.
   int   m_state;
   int   m_mode;
   int   m_rate;
   int   m_elapsed;
   int   m_pos;
   int   m_up;
   int   m_blink_on;
   logic m_ready;
   logic m_pulse;

   always #5 clk = ~clk;

   led_seq_ctrl #(
      .N_LED    (N_LED),
      .TICK_DIV (TICK_DIV),
      .DIV_W    (DIV_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_mode   (cfg_mode),
      .cfg_rate   (cfg_rate),
      .start      (start),
      .pause      (pause),
      .stop       (stop),
      .led        (led),
      .busy       (busy),
      .step_pulse (step_pulse)
   );

   function automatic vec_t mkVec(logic v, logic [1:0] md, logic [3:0] rt, logic st, logic pa, logic sp,
                                  int n, logic [7:0] l, logic b, logic r, logic p);
      vec_t x;
      x.valid = v; x.mode = md; x.rate = rt; x.start = st; x.pause = pa; x.stop = sp;
      x.n = n; x.led = l; x.busy = b; x.ready = r; x.pulse = p;
      return x;
   endfunction

   function automatic logic [7:0] modelLed();
      logic [7:0] r;
      r = '0;
      if (m_state != 0) begin
         case (m_mode)
            1:       r = (m_blink_on != 0) ? 8'hFF : 8'h00;
            2, 3:    r[m_pos] = 1'b1;
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   task automatic modelReset();
      m_state = 0; m_mode = 0; m_rate = 0; m_elapsed = 0;
      m_pos = 0; m_up = 1; m_blink_on = 0; m_ready = 1'b0; m_pulse = 1'b0;
   endtask

   task automatic modelAdvance();
      case (m_mode)
         1: m_blink_on = (m_blink_on != 0) ? 0 : 1;
         2: m_pos = (m_pos + 1) % N_LED;
         3: begin
            if (m_up != 0) begin
               if (m_pos == N_LED - 1) begin m_pos = N_LED - 2; m_up = 0; end
               else m_pos = m_pos + 1;
            end else begin
               if (m_pos == 0) begin m_pos = 1; m_up = 1; end
               else m_pos = m_pos - 1;
            end
         end
         default: ;
      endcase
   endtask

   task automatic modelEdge();
      int nxt;
      bit hs;
      hs = cfg_valid && m_ready;
      nxt = m_state;
      case (m_state)
         0: if (!stop && !pause && start) nxt = 1;
         1: if (stop) nxt = 0; else if (pause) nxt = 2;
         2: if (stop) nxt = 0; else if (start && !pause) nxt = 1;
         default: nxt = 0;
      endcase
      if (hs) begin
         m_mode = int'(cfg_mode);
         m_rate = int'(cfg_rate);
      end
      m_pulse = 1'b0;
      if (nxt == 0) begin
         m_elapsed = 0;
      end else if (m_state == 0) begin
         m_elapsed = 0; m_pos = 0; m_up = 1; m_blink_on = 1;
      end else if (m_state == 1) begin
         m_elapsed = m_elapsed + 1;
         if (m_elapsed == (m_rate + 1) * TICK_DIV) begin
            m_elapsed = 0;
            m_pulse = 1'b1;
            modelAdvance();
         end
      end
      m_ready = (nxt == 0);
      m_state = nxt;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkAll(input string tag, input logic [7:0] l, input logic b, input logic r, input logic p);
      checkOutput({tag, " led"}, 16'(led), 16'(l));
      checkOutput({tag, " busy"}, 16'(busy), 16'(b));
      checkOutput({tag, " cfg_ready"}, 16'(cfg_ready), 16'(r));
      checkOutput({tag, " step_pulse"}, 16'(step_pulse), 16'(p));
   endtask

   task automatic clearInputs();
      cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_rate = 4'd0;
      start = 1'b0; pause = 1'b0; stop = 1'b0;
   endtask

   task automatic cycle();
      @(posedge clk);
      if (reset) modelReset();
      else modelEdge();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input int idx);
      vec_t v;
      v = vecs[idx];
      cfg_valid = v.valid; cfg_mode = v.mode; cfg_rate = v.rate;
      start = v.start; pause = v.pause; stop = v.stop;
      cycle();
      clearInputs();
      for (int k = 1; k < v.n; k++) cycle();
      checkAll($sformatf("vec%0d", idx), v.led, v.busy, v.ready, v.pulse);
   endtask

   initial begin
      vecs[0]  = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 1,  8'h00, 0, 1, 0);
      vecs[1]  = mkVec(1, 2'd2, 4'd0, 1, 0, 0, 1,  8'h01, 1, 0, 0);
      vecs[2]  = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 3,  8'h01, 1, 0, 0);
      vecs[3]  = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 1,  8'h02, 1, 0, 1);
      vecs[4]  = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 1,  8'h02, 1, 0, 0);
      vecs[5]  = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 3,  8'h04, 1, 0, 1);
      vecs[6]  = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 20, 8'h80, 1, 0, 1);
      vecs[7]  = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 4,  8'h01, 1, 0, 1);
      vecs[8]  = mkVec(0, 2'd0, 4'd0, 1, 0, 1, 1,  8'h00, 0, 1, 0);
      vecs[9]  = mkVec(1, 2'd3, 4'd1, 1, 0, 0, 1,  8'h01, 1, 0, 0);
      vecs[10] = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 8,  8'h02, 1, 0, 1);
      vecs[11] = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 48, 8'h80, 1, 0, 1);
      vecs[12] = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 8,  8'h40, 1, 0, 1);
      vecs[13] = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 48, 8'h01, 1, 0, 1);
      vecs[14] = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 8,  8'h02, 1, 0, 1);
      vecs[15] = mkVec(0, 2'd0, 4'd0, 0, 0, 1, 1,  8'h00, 0, 1, 0);
      vecs[16] = mkVec(1, 2'd1, 4'd0, 1, 0, 0, 1,  8'hFF, 1, 0, 0);
      vecs[17] = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 4,  8'h00, 1, 0, 1);
      vecs[18] = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 1,  8'h00, 1, 0, 0);
      vecs[19] = mkVec(0, 2'd0, 4'd0, 0, 1, 0, 10, 8'h00, 1, 0, 0);
      vecs[20] = mkVec(0, 2'd0, 4'd0, 1, 0, 0, 1,  8'h00, 1, 0, 0);
      vecs[21] = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 1,  8'h00, 1, 0, 0);
      vecs[22] = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 1,  8'hFF, 1, 0, 1);
      vecs[23] = mkVec(1, 2'd0, 4'd0, 0, 0, 0, 1,  8'hFF, 1, 0, 0);
      vecs[24] = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 2,  8'hFF, 1, 0, 0);
      vecs[25] = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 1,  8'h00, 1, 0, 1);
      vecs[26] = mkVec(0, 2'd0, 4'd0, 1, 0, 0, 1,  8'h00, 1, 0, 0);
      vecs[27] = mkVec(0, 2'd0, 4'd0, 0, 0, 0, 4,  8'h00, 1, 0, 1);
      vecs[28] = mkVec(0, 2'd0, 4'd0, 0, 0, 1, 1,  8'h00, 0, 1, 0);

      clearInputs();
      modelReset();
      reset = 1'b1;
      repeat (3) cycle();
      checkAll("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      for (int i = 0; i <= 25; i++) applyStimulus(i);

      // Asynchronous reset in the middle of a running BLINK sequence.
      reset = 1'b1;
      modelReset();
      #2;
      checkAll("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 26; i <= 28; i++) applyStimulus(i);

      // Randomized traffic compared cycle by cycle with the model.
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         cfg_valid = ($urandom_range(0, 99) < 40);
         cfg_mode  = 2'($urandom_range(0, 3));
         cfg_rate  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
         start     = ($urandom_range(0, 99) < 25);
         pause     = ($urandom_range(0, 99) < 8);
         stop      = ($urandom_range(0, 99) < 3);
         cycle();
         checkOutput("rand led", 16'(led), 16'(modelLed()));
         checkOutput("rand busy", 16'(busy), 16'(m_state != 0));
         checkOutput("rand cfg_ready", 16'(cfg_ready), 16'(m_ready));
         checkOutput("rand step_pulse", 16'(step_pulse), 16'(m_pulse));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
